// File: rtl/neuron_seq_ctrl.sv
// neuron_seq_ctrl: buffers one N_IN-sample vector, then clears the neuron,
// streams the samples back-to-back and waits (with timeout) for its result.
module neuron_seq_ctrl #(
    parameter int DATA_W  = 12,
    parameter int RES_W   = 23,
    parameter int N_IN    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic signed [DATA_W-1:0] ld_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
    output logic signed [RES_W-1:0]  result_out,
    output logic                     nrn_rst,
    output logic                     nrn_valid_in,
    output logic signed [DATA_W-1:0] nrn_multiplicand,
    input  logic                     nrn_valid_out,
    input  logic signed [RES_W-1:0]  nrn_result
);

    localparam int CNT_W  = $clog2(N_IN + 1);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(N_IN);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_IN - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_CLEAR,
        S_STREAM,
        S_WAIT
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [CNT_W-1:0]          fill_cnt;
    logic [CNT_W-1:0]          beat_idx;
    logic [CNT_W-1:0]          beat_next;
    logic [WCNT_W-1:0]         wait_cnt;
    logic                      ld_fire;
    logic                      done_next;
    logic                      err_next;
    logic                      fill_clear;
    logic signed [DATA_W-1:0]  sample_buf [N_IN];

    // Loads are only accepted while idle and the buffer still has room
    assign ld_ready = (state == S_IDLE) && (fill_cnt < CNT_FULL);
    assign ld_fire  = ld_valid && ld_ready;
    // The neuron is held in reset with us, and pulsed once before each vector
    assign nrn_rst  = rst || (state == S_CLEAR);

    // Next-state, beat index and completion pulses
    always_comb begin
        state_next = state;
        beat_next  = beat_idx;
        done_next  = 1'b0;
        err_next   = 1'b0;
        fill_clear = 1'b0;
        case (state)
            S_IDLE: begin
                if ((fill_cnt >= CNT_FULL) || (ld_fire && (fill_cnt == CNT_LAST)))
                    state_next = S_READY;
            end
            S_READY: begin
                if (start)
                    state_next = S_CLEAR;
            end
            S_CLEAR: begin
                state_next = S_STREAM;
                beat_next  = '0;
            end
            S_STREAM: begin
                if (beat_idx == CNT_LAST)
                    state_next = S_WAIT;
                else
                    beat_next = beat_idx + CNT_W'(1);
            end
            S_WAIT: begin
                // A response on the final wait cycle still wins over the timeout
                if (nrn_valid_out) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                    fill_clear = 1'b1;
                end else if (wait_cnt == WCNT_LAST) begin
                    state_next = S_IDLE;
                    err_next   = 1'b1;
                    fill_clear = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Control state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            fill_cnt         <= '0;
            beat_idx         <= '0;
            wait_cnt         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_timeout      <= 1'b0;
            result_out       <= '0;
            nrn_valid_in     <= 1'b0;
            nrn_multiplicand <= '0;
        end else begin
            state       <= state_next;
            beat_idx    <= beat_next;
            busy        <= (state_next == S_CLEAR) || (state_next == S_STREAM) ||
                           (state_next == S_WAIT);
            done        <= done_next;
            err_timeout <= err_next;
            wait_cnt    <= (state == S_WAIT) ? wait_cnt + WCNT_W'(1) : '0;

            if (fill_clear)
                fill_cnt <= '0;
            else if (ld_fire)
                fill_cnt <= fill_cnt + CNT_W'(1);

            // Beat data is selected one cycle ahead so it lines up with valid
            nrn_valid_in     <= (state_next == S_STREAM);
            nrn_multiplicand <= (state_next == S_STREAM) ? sample_buf[beat_next] : '0;

            if (done_next)
                result_out <= nrn_result;
        end
    end

    // Sample storage; contents are meaningless until refilled, so no reset
    always_ff @(posedge clk) begin
        if (ld_fire)
            sample_buf[fill_cnt] <= ld_data;
    end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// tb_neuron_seq_ctrl: table-driven, hand-written and randomized checks of the
// neuron sequencer against a transaction-level expectation model.
module tb_neuron_seq_ctrl;

    localparam int DATA_W  = 12;
    localparam int RES_W   = 23;
    localparam int N_IN    = 3;
    localparam int TIMEOUT = 16;

    typedef logic [N_IN-1:0][DATA_W-1:0] vec_t;

    // delay: cycles after the last beat at which the neuron answers (0 = never)
    // spur : beat index during which a stray valid_out is raised (-1 = none)
    typedef struct {
        vec_t             samples;
        int               delay;
        logic [RES_W-1:0] res;
        int               spur;
        bit               exp_done;
        int               exp_cycles;
        logic [RES_W-1:0] exp_result;
    } vec_rec_t;

    logic              clk;
    logic              rst;
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              start;
    logic              busy;
    logic              done;
    logic              err_timeout;
    logic [RES_W-1:0]  result_out;
    logic              nrn_rst;
    logic              nrn_valid_in;
    logic [DATA_W-1:0] nrn_multiplicand;
    logic              nrn_valid_out;
    logic [RES_W-1:0]  nrn_result;

    int errors = 0;
    int checks = 0;
    int mon_done = 0, mon_err = 0, mon_beats = 0;
    int exp_done_cnt = 0, exp_err_cnt = 0, exp_beats = 0;
    logic [RES_W-1:0] ref_result;

    vec_rec_t tbl [6];

    neuron_seq_ctrl #(
        .DATA_W(DATA_W), .RES_W(RES_W), .N_IN(N_IN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .start(start), .busy(busy), .done(done), .err_timeout(err_timeout),
        .result_out(result_out), .nrn_rst(nrn_rst), .nrn_valid_in(nrn_valid_in),
        .nrn_multiplicand(nrn_multiplicand), .nrn_valid_out(nrn_valid_out),
        .nrn_result(nrn_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole-run observation of beats and pulses, mid-cycle
    always @(negedge clk) begin
        if (nrn_valid_in) mon_beats++;
        if (done) mon_done++;
        if (err_timeout) mon_err++;
        checks++;
        if (done && err_timeout) begin
            errors++;
            $display("FAIL done_err_overlap: done=%0b err=%0b, required not both high", done, err_timeout);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                input logic [DATA_W-1:0] c);
        vec_t v;
        v[0] = a;
        v[1] = b;
        v[2] = c;
        return v;
    endfunction

    // Outcome rule: answer within TIMEOUT wait cycles -> done one cycle later,
    // otherwise error after TIMEOUT wait cycles with the old result kept.
    function automatic vec_rec_t model(input vec_t s, input int d, input logic [RES_W-1:0] r,
                                       input int spur, input logic [RES_W-1:0] prev);
        vec_rec_t rec;
        rec.samples    = s;
        rec.delay      = d;
        rec.res        = r;
        rec.spur       = spur;
        rec.exp_done   = (d >= 1) && (d <= TIMEOUT);
        rec.exp_cycles = rec.exp_done ? d + 1 : TIMEOUT + 1;
        rec.exp_result = rec.exp_done ? r : prev;
        return rec;
    endfunction

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < N_IN; i++) begin
            ld_valid = 1'b1;
            ld_data  = v[i];
            chk("ld_ready_during_load", 32'(ld_ready), 32'd1);
            tick;
        end
        ld_valid = 1'b0;
        ld_data  = '0;
        chk("ld_ready_when_full", 32'(ld_ready), 32'd0);
        chk("busy_when_ready", 32'(busy), 32'd0);
        chk("valid_in_when_ready", 32'(nrn_valid_in), 32'd0);
    endtask

    // Starts a loaded vector and plays the neuron's side of the exchange
    task automatic process(input vec_rec_t r);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("clear_nrn_rst", 32'(nrn_rst), 32'd1);
        chk("clear_valid_in", 32'(nrn_valid_in), 32'd0);
        chk("clear_busy", 32'(busy), 32'd1);
        for (int i = 0; i < N_IN; i++) begin
            tick;
            chk("beat_valid", 32'(nrn_valid_in), 32'd1);
            chk("beat_data", 32'(nrn_multiplicand), 32'(r.samples[i]));
            chk("beat_nrn_rst", 32'(nrn_rst), 32'd0);
            start         = (i == 0);
            nrn_valid_out = (r.spur == i);
            nrn_result    = RES_W'($urandom);
        end
        start         = 1'b0;
        nrn_valid_out = 1'b0;
        for (int c = 1; c <= TIMEOUT + 2; c++) begin
            tick;
            chk("wait_done", 32'(done), 32'((c == r.exp_cycles) && r.exp_done));
            chk("wait_err", 32'(err_timeout), 32'((c == r.exp_cycles) && !r.exp_done));
            chk("wait_busy", 32'(busy), 32'(c != r.exp_cycles));
            chk("wait_valid_in", 32'(nrn_valid_in), 32'd0);
            chk("wait_mult", 32'(nrn_multiplicand), 32'd0);
            if (c == r.exp_cycles) begin
                chk("end_ld_ready", 32'(ld_ready), 32'd1);
                chk("end_result", 32'(result_out), 32'(r.exp_result));
                break;
            end
            nrn_valid_out = (c == r.delay);
            nrn_result    = (c == r.delay) ? r.res : RES_W'($urandom);
        end
        nrn_valid_out = 1'b0;
        tick;
        chk("pulse_done_low", 32'(done), 32'd0);
        chk("pulse_err_low", 32'(err_timeout), 32'd0);
        chk("held_result", 32'(result_out), 32'(r.exp_result));
        if (r.exp_done) exp_done_cnt++;
        else exp_err_cnt++;
        exp_beats += N_IN;
        ref_result = r.exp_result;
    endtask

    initial begin
        vec_rec_t r;
        vec_t     v;

        tbl[0] = '{mk(12'h05C, 12'h0E4, 12'h1C0), 2,  23'h012345, -1, 1'b1, 3,  23'h012345};
        tbl[1] = '{mk(12'h111, 12'h222, 12'h333), 0,  23'h7FFFFF, -1, 1'b0, 17, 23'h012345};
        tbl[2] = '{mk(12'h800, 12'h7FF, 12'h001), 16, 23'h0ABCDE, -1, 1'b1, 17, 23'h0ABCDE};
        tbl[3] = '{mk(12'hFFF, 12'h000, 12'hABC), 17, 23'h033333, -1, 1'b0, 17, 23'h0ABCDE};
        tbl[4] = '{mk(12'h123, 12'h456, 12'h789), 3,  23'h000777,  1, 1'b1, 4,  23'h000777};
        tbl[5] = '{mk(12'h0AA, 12'h055, 12'hF0F), 1,  23'h400001,  0, 1'b1, 2,  23'h400001};

        rst = 1'b1; ld_valid = 1'b0; ld_data = '0; start = 1'b0;
        nrn_valid_out = 1'b0; nrn_result = '0;
        tick;
        tick;
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_result", 32'(result_out), 32'd0);
        chk("rst_valid_in", 32'(nrn_valid_in), 32'd0);
        chk("rst_mult", 32'(nrn_multiplicand), 32'd0);
        chk("rst_nrn_rst", 32'(nrn_rst), 32'd1);
        rst = 1'b0;
        #1;
        chk("idle_nrn_rst", 32'(nrn_rst), 32'd0);
        ref_result = '0;

        for (int t = 0; t < 6; t++) begin
            load_vec(tbl[t].samples);
            process(tbl[t]);
        end

        // Partial load: start ignored, then extra loads while READY dropped
        v = mk(12'h321, 12'h654, 12'h987);
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = v[i];
            chk("partial_ld_ready", 32'(ld_ready), 32'd1);
            tick;
        end
        ld_valid = 1'b0;
        start    = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("partial_busy", 32'(busy), 32'd0);
            chk("partial_nrn_rst", 32'(nrn_rst), 32'd0);
            chk("partial_valid_in", 32'(nrn_valid_in), 32'd0);
            chk("partial_ld_ready_kept", 32'(ld_ready), 32'd1);
            tick;
        end
        ld_valid = 1'b1;
        ld_data  = v[2];
        chk("third_ld_ready", 32'(ld_ready), 32'd1);
        tick;
        ld_data = 12'hEEE;
        for (int k = 0; k < 2; k++) begin
            chk("extra_ld_ready", 32'(ld_ready), 32'd0);
            tick;
        end
        ld_valid = 1'b0;
        process(model(v, 4, 23'h05AA55, -1, ref_result));

        // Reset during the second stream beat aborts without any pulse
        v = mk(12'h0F0, 12'h00F, 12'h5A5);
        load_vec(v);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("abort_beat0", 32'(nrn_multiplicand), 32'(v[0]));
        tick;
        chk("abort_beat1_valid", 32'(nrn_valid_in), 32'd1);
        chk("abort_beat1", 32'(nrn_multiplicand), 32'(v[1]));
        rst = 1'b1;
        tick;
        chk("abort_valid_in", 32'(nrn_valid_in), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ld_ready", 32'(ld_ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err_timeout), 32'd0);
        chk("abort_nrn_rst", 32'(nrn_rst), 32'd1);
        chk("abort_result", 32'(result_out), 32'd0);
        rst = 1'b0;
        exp_beats += 2;
        ref_result = '0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("post_abort_done", 32'(done), 32'd0);
            chk("post_abort_err", 32'(err_timeout), 32'd0);
            chk("post_abort_busy", 32'(busy), 32'd0);
        end
        v = mk(12'h246, 12'h8AC, 12'h135);
        load_vec(v);
        process(model(v, 5, 23'h013579, -1, ref_result));

        // Randomized vectors against the outcome model
        for (int n = 0; n < 24; n++) begin
            v = mk(DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom));
            r = model(v, int'($urandom_range(0, TIMEOUT + 4)), RES_W'($urandom),
                      int'($urandom_range(0, N_IN)) - 1, ref_result);
            load_vec(v);
            process(r);
        end

        tick;
        chk("total_done_pulses", 32'(mon_done), 32'(exp_done_cnt));
        chk("total_err_pulses", 32'(mon_err), 32'(exp_err_cnt));
        chk("total_beats", 32'(mon_beats), 32'(exp_beats));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
